// File: rtl/prog_freq_divider.sv
// Multi-channel programmable clock divider. Each channel counts to its divisor and emits a tick.
// The output is either a 50% duty toggle clock or a copy of the tick.
module prog_freq_divider #(
   parameter int unsigned          NCH     = 3,
   parameter int unsigned          CNT_W   = 27,
   parameter logic [NCH*CNT_W-1:0] DIV_RST = {27'd500000, 27'd50000, 27'd50000000}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       i_en,
   input  logic [NCH-1:0]       i_mode,
   input  logic [NCH*CNT_W-1:0] i_div_val,
   input  logic [NCH-1:0]       i_load,
   input  logic                 i_sync_clr,
   output logic [NCH-1:0]       o_clk_out,
   output logic [NCH-1:0]       o_tick,
   output logic [NCH-1:0]       o_busy
);

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_act;
      logic [CNT_W-1:0] r_pend;
      logic             r_pend_vld;
      logic             r_tick;
      logic             r_clk_out;
      logic             r_mode;
      logic [CNT_W-1:0] w_div;
      logic [CNT_W-1:0] w_last;
      logic             w_tc;
      logic             w_load_now;
      logic             w_apply;

      always_comb begin
         w_div      = i_div_val[g*CNT_W +: CNT_W];
         // Effective divisor is max(act,1), so the last count is act-1, or 0 when act is 0
         w_last     = (r_act == '0) ? '0 : r_act - CNT_W'(1);
         // >= keeps a counter held above a freshly shrunk divisor from running to wrap
         w_tc       = i_en[g] & (r_cnt >= w_last);
         w_load_now = i_load[g] & (w_tc | i_sync_clr);
         w_apply    = r_pend_vld & (w_tc | i_sync_clr | ~i_en[g]);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_act      <= DIV_RST[g*CNT_W +: CNT_W];
            r_pend     <= DIV_RST[g*CNT_W +: CNT_W];
            r_pend_vld <= 1'b0;
         end else if (w_load_now) begin
            r_act      <= w_div;
            r_pend     <= w_div;
            r_pend_vld <= 1'b0;
         end else begin
            if (w_apply) begin
               r_act      <= r_pend;
               r_pend_vld <= 1'b0;
            end
            if (i_load[g]) begin
               r_pend     <= w_div;
               r_pend_vld <= 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
            r_mode    <= 1'b0;
         end else begin
            r_mode <= i_mode[g];
            if (i_sync_clr) begin
               r_cnt     <= '0;
               r_tick    <= 1'b0;
               r_clk_out <= 1'b0;
            end else begin
               r_tick <= w_tc;
               if (i_en[g]) begin
                  r_cnt <= w_tc ? '0 : r_cnt + CNT_W'(1);
               end
               // Pulse mode follows the tick; the first toggle cycle after pulse starts from 0
               if (i_mode[g] || r_mode) begin
                  r_clk_out <= w_tc;
               end else begin
                  r_clk_out <= r_clk_out ^ w_tc;
               end
            end
         end
      end

      assign o_tick[g]    = r_tick;
      assign o_clk_out[g] = r_clk_out;
      assign o_busy[g]    = r_pend_vld;
   end

endmodule
